ifu_fetch_ctrl: RTL and testbench

- Fetch sequencer for the instruction fetch unit (IFU).
- Drives the IFU's PC-set, IR-set and PC-source-mux selects, and runs the request/response handshake with instruction memory.
- Handles decode back-pressure, and jump/branch redirects that arrive while a fetch is outstanding.
- Sits between the IFU datapath, instruction memory and the decode stage.

---
 rtl/ifu_fetch_ctrl.sv | 156 +++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer for the IFU: drives PC/IR load enables and PC source selects,
// and runs the request/response handshake with instruction memory.
module ifu_fetch_ctrl #(
  parameter int BOOT_DELAY     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       ifc_clock_in,
  input  logic       ifc_reset_in,
  output logic       imem_req_out,
  input  logic       imem_ack_in,
  input  logic       imem_rvalid_in,
  input  logic       dec_ready_in,
  input  logic       jump_req_in,
  input  logic       branch_req_in,
  output logic       pc_set_out,
  output logic       ir_set_out,
  output logic       pc_mux_sel_out,
  output logic       pc_branch_sel_out,
  output logic       ir_valid_out,
  output logic       fetch_fault_out,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam int BW = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'((BOOT_DELAY > 0) ? BOOT_DELAY - 1 : 0);
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic BOOT_SKIP = (BOOT_DELAY == 0) ? 1'b1 : 1'b0;
  localparam logic TMO_EN    = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;

  state_t        state_r, state_nxt_s;
  logic [BW-1:0] boot_cnt_r, boot_cnt_nxt_s;
  logic [TW-1:0] tmo_cnt_r, tmo_cnt_nxt_s;
  logic          discard_r, discard_nxt_s;
  logic          redirect_s;
  logic          pc_set_s;
  logic          ir_set_s;
  logic          pc_mux_sel_s;
  logic          pc_branch_sel_s;

  assign redirect_s = jump_req_in | branch_req_in;

  // State and counter registers
  always_ff @(posedge ifc_clock_in or negedge ifc_reset_in) begin
    if (!ifc_reset_in) begin
      state_r    <= ST_BOOT;
      boot_cnt_r <= '0;
      tmo_cnt_r  <= '0;
      discard_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      boot_cnt_r <= boot_cnt_nxt_s;
      tmo_cnt_r  <= tmo_cnt_nxt_s;
      discard_r  <= discard_nxt_s;
    end
  end

  // Next-state logic and Mealy load pulses
  always_comb begin
    state_nxt_s    = state_r;
    boot_cnt_nxt_s = boot_cnt_r;
    tmo_cnt_nxt_s  = tmo_cnt_r;
    discard_nxt_s  = discard_r;
    pc_set_s       = 1'b0;
    ir_set_s       = 1'b0;
    case (state_r)
      ST_BOOT: begin
        if (BOOT_SKIP || (boot_cnt_r == BOOT_LAST)) begin
          state_nxt_s    = ST_FETCH;
          boot_cnt_nxt_s = '0;
        end else begin
          boot_cnt_nxt_s = boot_cnt_r + {{(BW-1){1'b0}}, 1'b1};
        end
      end
      ST_FETCH: begin
        pc_set_s = redirect_s;
        if (imem_ack_in) begin
          // A redirect accepted alongside the ack leaves a stale response in flight
          state_nxt_s   = ST_WAIT;
          tmo_cnt_nxt_s = '0;
          discard_nxt_s = redirect_s;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (!imem_rvalid_in) begin
          tmo_cnt_nxt_s = tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
          if (TMO_EN && (tmo_cnt_r == TMO_LAST)) begin
            state_nxt_s = ST_FAULT;
          end else if (redirect_s) begin
            pc_set_s      = 1'b1;
            discard_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else if (redirect_s) begin
          pc_set_s      = 1'b1;
          discard_nxt_s = 1'b0;
          state_nxt_s   = ST_FETCH;
        end else if (discard_r) begin
          discard_nxt_s = 1'b0;
          state_nxt_s   = ST_FETCH;
        end else begin
          ir_set_s    = 1'b1;
          state_nxt_s = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_s || dec_ready_in) begin
          pc_set_s    = 1'b1;
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_FAULT: begin
        state_nxt_s = ST_FAULT;
      end
      default: begin
        state_nxt_s = ST_FAULT;
      end
    endcase
  end

  // PC source selects, only meaningful while the PC is being loaded
  always_comb begin
    pc_branch_sel_s = 1'b0;
    pc_mux_sel_s    = 1'b0;
    if (pc_set_s) begin
      pc_branch_sel_s = branch_req_in;
      pc_mux_sel_s    = jump_req_in & ~branch_req_in;
    end else begin
      pc_branch_sel_s = 1'b0;
      pc_mux_sel_s    = 1'b0;
    end
  end

  assign imem_req_out      = (state_r == ST_FETCH);
  assign ir_valid_out      = (state_r == ST_HOLD);
  assign fetch_fault_out   = (state_r == ST_FAULT);
  assign state_out         = state_r;
  assign pc_set_out        = pc_set_s;
  assign ir_set_out        = ir_set_s;
  assign pc_mux_sel_out    = pc_mux_sel_s;
  assign pc_branch_sel_out = pc_branch_sel_s;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Scoreboard bench for ifu_fetch_ctrl: a rule-level model predicts each cycle's
// outputs and the resulting PC; a monitor compares them on the falling edge.
module tb_ifu_fetch_ctrl;

  localparam int BOOT_DELAY     = 4;
  localparam int TIMEOUT_CYCLES = 8;
  localparam int P_BOOT = 0, P_FETCH = 1, P_WAIT = 2, P_HOLD = 3, P_FAULT = 4;

  typedef struct packed {
    logic [9:0]  sig;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0, imem_rvalid = 1'b0, dec_ready = 1'b0;
  logic        jump_req = 1'b0, branch_req = 1'b0;
  logic        pc_set, ir_set, pc_mux_sel, pc_branch_sel, ir_valid, fetch_fault;
  logic [2:0]  state;
  logic [31:0] jump_addr = 32'd0, branch_addr = 32'd0, dut_pc;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;
  int   cyc    = 0;

  // model state
  int          m_phase = P_BOOT;
  int          m_boot_left = BOOT_DELAY;
  int          m_wait = 0;
  bit          m_stale = 1'b0;
  logic [31:0] m_pc = 32'd0;

  ifu_fetch_ctrl #(.BOOT_DELAY(BOOT_DELAY), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .ifc_clock_in      (clk),
    .ifc_reset_in      (rst_n),
    .imem_req_out      (imem_req),
    .imem_ack_in       (imem_ack),
    .imem_rvalid_in    (imem_rvalid),
    .dec_ready_in      (dec_ready),
    .jump_req_in       (jump_req),
    .branch_req_in     (branch_req),
    .pc_set_out        (pc_set),
    .ir_set_out        (ir_set),
    .pc_mux_sel_out    (pc_mux_sel),
    .pc_branch_sel_out (pc_branch_sel),
    .ir_valid_out      (ir_valid),
    .fetch_fault_out   (fetch_fault),
    .state_out         (state)
  );

  always #5 clk = ~clk;

  // IFU PC register steered by the DUT's load enable and selects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          dut_pc <= 32'd0;
    else if (pc_set)     dut_pc <= pc_branch_sel ? branch_addr : (pc_mux_sel ? jump_addr : dut_pc + 32'd4);
    else                 dut_pc <= dut_pc;
  end

  task automatic model_step(input bit rst, ack, rv, dr, j, b, output exp_t e);
    bit pcs, irs, redir;
    int nxt;
    e = '0;
    if (!rst) begin
      m_phase = P_BOOT; m_boot_left = BOOT_DELAY; m_wait = 0; m_stale = 1'b0; m_pc = 32'd0;
      return;
    end
    redir = j | b;
    pcs = 1'b0; irs = 1'b0; nxt = m_phase;
    case (m_phase)
      P_BOOT:  if (m_boot_left <= 1) nxt = P_FETCH; else m_boot_left--;
      P_FETCH: begin
        pcs = redir;
        if (ack) begin nxt = P_WAIT; m_wait = 0; m_stale = redir; end
      end
      P_WAIT: begin
        if (!rv) begin
          m_wait++;
          if (TIMEOUT_CYCLES != 0 && m_wait >= TIMEOUT_CYCLES) nxt = P_FAULT;
          else if (redir) begin pcs = 1'b1; m_stale = 1'b1; end
        end else begin
          if (redir) pcs = 1'b1;
          else if (!m_stale) irs = 1'b1;
          nxt = (redir || m_stale) ? P_FETCH : P_HOLD;
          m_stale = 1'b0;
        end
      end
      P_HOLD:  if (redir || dr) begin pcs = 1'b1; nxt = P_FETCH; end
      default: ;
    endcase
    e.sig = {m_phase == P_FETCH, pcs, irs, pcs && j && !b, pcs && b,
             m_phase == P_HOLD, m_phase == P_FAULT, 3'(m_phase)};
    e.pc = m_pc;
    if (pcs) m_pc = b ? branch_addr : (j ? jump_addr : m_pc + 32'd4);
    m_phase = nxt;
  endtask

  task automatic drive(input bit rst, ack, rv, dr, j, b);
    exp_t e;
    @(posedge clk);
    #1;
    jump_addr   = $urandom & 32'hFFFF_FFFC;
    branch_addr = $urandom & 32'hFFFF_FFFC;
    rst_n = rst; imem_ack = ack; imem_rvalid = rv; dec_ready = dr;
    jump_req = j; branch_req = b;
    model_step(rst, ack, rv, dr, j, b, e);
    sb_q.push_back(e);
  endtask

  // Monitor: pop one expectation per presented cycle and compare
  initial begin
    exp_t e;
    logic [9:0] got;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cyc++;
        got = {imem_req, pc_set, ir_set, pc_mux_sel, pc_branch_sel, ir_valid, fetch_fault, state};
        checks++;
        if (got !== e.sig) begin
          fails++;
          $display("FAIL outputs cyc=%0d got=%b exp=%b (req,pcset,irset,mux,bsel,irv,fault,state)", cyc, got, e.sig);
        end else passed++;
        checks++;
        if (dut_pc !== e.pc) begin
          fails++;
          $display("FAIL pc cyc=%0d got=%h exp=%h", cyc, dut_pc, e.pc);
        end else passed++;
      end
    end
  end

  initial begin
    // reset, boot, then the plain fetch/wait/hold cadence
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) drive(1, 1, 1, 1, 0, 0);
    // decode stall in HOLD
    for (int k = 0; k < 6 && m_phase != P_HOLD; k++) drive(1, 1, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    // branch+jump while WAITing, stale response two cycles later
    for (int k = 0; k < 6 && m_phase != P_WAIT; k++) drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    // jump coincident with ack in FETCH, stale response discarded
    for (int k = 0; k < 6 && m_phase != P_FETCH; k++) drive(1, 0, 1, 1, 0, 0);
    drive(1, 1, 0, 0, 1, 0);
    drive(1, 0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 1, 1, 0, 0);
    // async reset while in HOLD, boot restarts
    for (int k = 0; k < 6 && m_phase != P_HOLD; k++) drive(1, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    for (int k = 0; k < 7; k++) drive(1, 1, 1, 1, 0, 0);
    // timeout into FAULT, inputs ignored, reset clears it immediately
    for (int k = 0; k < 6 && m_phase != P_WAIT; k++) drive(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < TIMEOUT_CYCLES + 2; k++) drive(1, 0, 0, 0, k == 3, 0);
    drive(1, 1, 1, 1, 0, 0);
    drive(1, 0, 1, 0, 1, 1);
    drive(1, 1, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    // randomized traffic with occasional resets
    for (int k = 0; k < 600; k++)
      drive($urandom_range(0, 59) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4,
            $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    for (int k = 0; k < 5 && sb_q.size() != 0; k++) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
